subbytes_share_arbiter: RTL and testbench
=========================================

Name: subbytes_share_arbiter

Overview:
- Shares one 16-byte S-box bank between two requesters: requester 0 is the cipher round datapath (full 128-bit state) and requester 1 is the key-expansion unit (SubWord in the low 32 bits, upper bytes don't-care).
- Arbitrates round-robin and registers the granted state into the bank.
- Tracks ownership of each in-flight word through the bank's fixed latency and steers each result back to its owner.
- Sits between the round/key-schedule controllers and the S-box bank instance.

Parameters:
- NB_BYTE, 8, bits per byte; any other value is a bad configuration.
- N_BYTES, 16, bytes per state word.
- SB_LATENCY, 0, S-box bank latency in cycles: 0 = combinational bank, 1 = bank built with its output register.
- PRIO_REQ0, 0, 1 = requester 0 has strict priority; 0 = round-robin.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-low reset (0 = reset).
- i_req0_valid  in  1  round datapath requests substitution.
- i_req0_state  in  N_BYTES*NB_BYTE  round datapath state.
- o_req0_ready  out  1  request 0 accepted this cycle.
- i_req1_valid  in  1  key expansion requests substitution.
- i_req1_state  in  N_BYTES*NB_BYTE  key word, zero-extended.
- o_req1_ready  out  1  request 1 accepted this cycle.
- o_sb_state  out  N_BYTES*NB_BYTE  registered state to the S-box bank.
- o_sb_valid  out  1  registered valid to the S-box bank.
- i_sb_state  in  N_BYTES*NB_BYTE  substituted state from the bank.
- i_sb_valid  in  1  valid from the bank.
- o_rsp0_valid  out  1  result for requester 0.
- o_rsp1_valid  out  1  result for requester 1.
- o_rsp_state  out  N_BYTES*NB_BYTE  shared result bus.
- o_busy  out  1  at least one word in flight.
- o_error  out  1  sticky valid/tag mismatch.

Behaviour:
- Reset: i_reset==0 at a rising edge clears all registers.
  - o_sb_valid=0, o_sb_state=0, tag pipeline=0, rr pointer=0 (requester 0 favoured next), o_error=0.
  - Outputs read 0 the cycle after reset: o_req*_ready, o_rsp*_valid, o_busy.
  - Reset mid-operation drops in-flight words; no response is issued for them.
  - While in reset, o_req*_ready=0.
- Arbitration (combinational, one grant per cycle):
  - Only one requester valid: it is granted.
  - Both valid, PRIO_REQ0=1: requester 0 is granted.
  - Both valid, PRIO_REQ0=0: the rr pointer's requester is granted, then the pointer moves to the other requester.
  - Pointer updates only on a contended grant; an uncontended grant leaves it unchanged.
  - o_reqN_ready=1 only for the granted requester. Grant = valid&&ready. No backpressure from the bank or the response side.
- Issue stage: on a grant at cycle t:
  - At t+1: o_sb_valid=1, o_sb_state = the granted state, issue tag = the granted index.
  - No grant: o_sb_valid=0, o_sb_state holds its value.
- Tag pipeline: {valid,tag} is delayed SB_LATENCY further cycles to line up with i_sb_valid. Depth is SB_LATENCY, so depth 0 is a direct wire.
- Response at cycle t+1+SB_LATENCY:
  - o_rsp_state = i_sb_state (combinational passthrough).
  - o_rsp0_valid = aligned_valid && tag==0 && i_sb_valid.
  - o_rsp1_valid = aligned_valid && tag==1 && i_sb_valid.
  - Both are never high together.
- Throughput: one word per cycle total. Back-to-back grants fill the pipeline without bubbles.
- o_busy = OR of the issue-stage valid and all tag-pipeline valids.
- Error: if i_sb_valid != aligned_valid in any cycle, o_error is set to 1 and held until reset. In that cycle the response valids are suppressed.
- Requester 1 payload: bytes 4..15 pass through untouched, and requester 1 ignores them in the result.

Test Plan:
- Reset: hold i_reset=0 for 3 cycles with both requests valid -> ready=0, o_sb_valid=0, o_busy=0, o_error=0. First grant after release goes to requester 0.
- Single requester, SB_LATENCY=0: req0 valid with state 0x00..00 at cycle 5 -> o_req0_ready=1 at 5, o_sb_valid at 6, o_rsp0_valid=1 at 6 with 0x6363…63. Repeat with SB_LATENCY=1 -> o_rsp0_valid at 7.
- Contention, round-robin: both valid continuously for 6 cycles -> grants 0,1,0,1,0,1. Responses alternate rsp0/rsp1 in the same order with no bubbles. Key word 0x00000001 returns low bytes 0x6363637C.
- Priority mode: PRIO_REQ0=1, both valid for 4 cycles -> requester 0 granted all 4 cycles and o_req1_ready stays 0. Drop req0 -> requester 1 granted the next cycle.
- Reset mid-flight: SB_LATENCY=1, issue 2 words, assert i_reset=0 the cycle after the 2nd grant -> no o_rsp*_valid pulses, o_busy=0 after reset.
- Error injection: force i_sb_valid=1 while the pipeline is empty -> o_error=1 the next cycle and it stays 1. Later responses show no spurious valid in the mismatch cycle. It clears only on reset.

Source files
------------

// File: rtl/subbytes_share_arbiter.sv
// Round-robin or priority arbiter that shares one S-box bank between the cipher round datapath
// (requester 0) and the key-expansion unit (requester 1), and routes each result back to its owner.
module subbytes_share_arbiter #(
    parameter int unsigned NB_BYTE    = 8,
    parameter int unsigned N_BYTES    = 16,
    parameter int unsigned SB_LATENCY = 0,
    parameter int unsigned PRIO_REQ0  = 0
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_req0_valid,
    input  logic [N_BYTES*NB_BYTE-1:0]   i_req0_state,
    output logic                         o_req0_ready,
    input  logic                         i_req1_valid,
    input  logic [N_BYTES*NB_BYTE-1:0]   i_req1_state,
    output logic                         o_req1_ready,
    output logic [N_BYTES*NB_BYTE-1:0]   o_sb_state,
    output logic                         o_sb_valid,
    input  logic [N_BYTES*NB_BYTE-1:0]   i_sb_state,
    input  logic                         i_sb_valid,
    output logic                         o_rsp0_valid,
    output logic                         o_rsp1_valid,
    output logic [N_BYTES*NB_BYTE-1:0]   o_rsp_state,
    output logic                         o_busy,
    output logic                         o_error
);

    localparam int unsigned W = N_BYTES * NB_BYTE;

    if (NB_BYTE != 8) begin : g_bad_cfg
        $error("subbytes_share_arbiter: NB_BYTE must be 8");
    end

    logic                  grant0;
    logic                  grant1;
    logic                  grant_any;
    logic                  contended;
    logic                  rr_q;
    logic                  rr_d;
    logic [W-1:0]          sb_state_q;
    logic [W-1:0]          sb_state_d;
    // Index 0 is the issue stage; index SB_LATENCY lines up with the bank output.
    logic [SB_LATENCY:0]   vld_q;
    logic [SB_LATENCY:0]   vld_d;
    logic [SB_LATENCY:0]   tag_q;
    logic [SB_LATENCY:0]   tag_d;
    logic [SB_LATENCY:0]   vld_shift;
    logic [SB_LATENCY:0]   tag_shift;
    logic                  error_q;
    logic                  error_d;
    logic                  aligned_valid;
    logic                  aligned_tag;
    logic                  mismatch;
    logic                  rsp_ok;

    // Arbitration; no grants at all while reset is asserted.
    always_comb begin
        contended = i_req0_valid && i_req1_valid;
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (i_reset) begin
            if (PRIO_REQ0 != 0) begin
                grant0 = i_req0_valid;
                grant1 = i_req1_valid && !i_req0_valid;
            end else if (contended) begin
                grant0 = !rr_q;
                grant1 = rr_q;
            end else begin
                grant0 = i_req0_valid;
                grant1 = i_req1_valid;
            end
        end
        grant_any = grant0 || grant1;
    end

    // Pointer only advances on a contended grant, toward the loser.
    always_comb begin
        rr_d = rr_q;
        if (!i_reset) begin
            rr_d = 1'b0;
        end else if (contended && (PRIO_REQ0 == 0)) begin
            rr_d = grant0;
        end
    end

    if (SB_LATENCY == 0) begin : g_lat0
        assign vld_shift = grant_any;
        assign tag_shift = grant1;
    end else begin : g_latn
        assign vld_shift = {vld_q[SB_LATENCY-1:0], grant_any};
        assign tag_shift = {tag_q[SB_LATENCY-1:0], grant1};
    end

    always_comb begin
        vld_d      = vld_shift;
        tag_d      = tag_shift;
        sb_state_d = sb_state_q;
        if (grant0) begin
            sb_state_d = i_req0_state;
        end else if (grant1) begin
            sb_state_d = i_req1_state;
        end
        if (!i_reset) begin
            vld_d      = '0;
            tag_d      = '0;
            sb_state_d = '0;
        end
    end

    assign aligned_valid = vld_q[SB_LATENCY];
    assign aligned_tag   = tag_q[SB_LATENCY];
    assign mismatch      = (i_sb_valid != aligned_valid);

    always_comb begin
        error_d = error_q || mismatch;
        if (!i_reset) begin
            error_d = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        rr_q       <= rr_d;
        sb_state_q <= sb_state_d;
        vld_q      <= vld_d;
        tag_q      <= tag_d;
        error_q    <= error_d;
    end

    // Words caught by a reset produce no response, even if already at the bank output.
    assign rsp_ok       = i_reset && aligned_valid && i_sb_valid && !mismatch;
    assign o_rsp0_valid = rsp_ok && !aligned_tag;
    assign o_rsp1_valid = rsp_ok && aligned_tag;
    assign o_rsp_state  = i_sb_state;

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;
    assign o_sb_valid   = vld_q[0];
    assign o_sb_state   = sb_state_q;
    assign o_busy       = |vld_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_subbytes_share_arbiter.sv
// Bench for subbytes_share_arbiter: three instances (latency 0 round-robin, latency 1
// round-robin, latency 0 priority) each with an AES S-box bank model, checked every cycle.
module tb_subbytes_share_arbiter;

    localparam logic [0:2047] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) begin
            int idx;
            idx = int'(s[b*8 +: 8]);
            r[b*8 +: 8] = SBOX_FLAT[idx*8 +: 8];
        end
        return r;
    endfunction

    logic         clk = 1'b0;
    logic         rst_n;
    logic         v0;
    logic         v1;
    logic [127:0] s0;
    logic [127:0] s1;
    logic [2:0]   inj;

    logic [2:0]   rdy0;
    logic [2:0]   rdy1;
    logic [2:0]   rsp0;
    logic [2:0]   rsp1;
    logic [2:0]   busy;
    logic [2:0]   err;
    logic [127:0] rsp_st [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int unsigned LAT  = (k == 1) ? 1 : 0;
        localparam int unsigned PRIO = (k == 2) ? 1 : 0;
        logic [127:0] sbo_state;
        logic [127:0] sbi_state;
        logic         sbo_valid;
        logic         sbi_valid;
        logic         bank_v_q;
        logic [127:0] bank_s_q;

        subbytes_share_arbiter #(
            .NB_BYTE   (8),
            .N_BYTES   (16),
            .SB_LATENCY(LAT),
            .PRIO_REQ0 (PRIO)
        ) u_dut (
            .i_clock     (clk),
            .i_reset     (rst_n),
            .i_req0_valid(v0),
            .i_req0_state(s0),
            .o_req0_ready(rdy0[k]),
            .i_req1_valid(v1),
            .i_req1_state(s1),
            .o_req1_ready(rdy1[k]),
            .o_sb_state  (sbo_state),
            .o_sb_valid  (sbo_valid),
            .i_sb_state  (sbi_state),
            .i_sb_valid  (sbi_valid),
            .o_rsp0_valid(rsp0[k]),
            .o_rsp1_valid(rsp1[k]),
            .o_rsp_state (rsp_st[k]),
            .o_busy      (busy[k]),
            .o_error     (err[k])
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                bank_v_q <= 1'b0;
                bank_s_q <= '0;
            end else begin
                bank_v_q <= sbo_valid;
                bank_s_q <= sub_state(sbo_state);
            end
        end

        assign sbi_valid = ((LAT == 1) ? bank_v_q : sbo_valid) | inj[k];
        assign sbi_state = (LAT == 1) ? bank_s_q : sub_state(sbo_state);
    end

    int vectors = 0;
    int miscompares = 0;
    int c = 4;

    // Reference model: per-cycle grant history, responses expected 1+latency cycles later.
    logic         hv [3][4];
    logic         ho [3][4];
    logic [127:0] hs [3][4];
    logic         rr_m [3];
    logic         err_m [3];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic clear_model(input int k);
        for (int i = 0; i < 4; i++) begin
            hv[k][i] = 1'b0;
            ho[k][i] = 1'b0;
            hs[k][i] = '0;
        end
        rr_m[k]  = 1'b0;
        err_m[k] = 1'b0;
    endtask

    task automatic model_cycle();
        for (int k = 0; k < 3; k++) begin
            int           lat;
            logic         prio;
            logic         g0;
            logic         g1;
            logic         al;
            logic         al_tag;
            logic [127:0] al_st;
            logic         mism;
            logic         e0;
            logic         e1;
            logic         busy_e;
            lat  = (k == 1) ? 1 : 0;
            prio = (k == 2);
            g0   = 1'b0;
            g1   = 1'b0;
            if (rst_n) begin
                if (v0 && v1) begin
                    if (prio || !rr_m[k]) g0 = 1'b1;
                    else g1 = 1'b1;
                end else begin
                    g0 = v0;
                    g1 = v1;
                end
            end
            al     = hv[k][(c - 1 - lat) % 4];
            al_tag = ho[k][(c - 1 - lat) % 4];
            al_st  = hs[k][(c - 1 - lat) % 4];
            mism   = rst_n && inj[k] && !al;
            e0     = rst_n && al && !al_tag;
            e1     = rst_n && al && al_tag;
            busy_e = hv[k][(c - 1) % 4] || (lat == 1 && hv[k][(c - 2) % 4]);
            chk($sformatf("inst%0d flags(rdy0,rdy1,rsp0,rsp1,busy,err) cyc%0d", k, c),
                {rdy0[k], rdy1[k], rsp0[k], rsp1[k], busy[k], err[k]},
                {g0, g1, e0, e1, busy_e, err_m[k]});
            if (e0 || e1) begin
                chk($sformatf("inst%0d rsp_state cyc%0d", k, c), rsp_st[k], sub_state(al_st));
            end
            hv[k][c % 4] = g0 || g1;
            ho[k][c % 4] = g1;
            hs[k][c % 4] = g0 ? s0 : s1;
            if (rst_n && v0 && v1 && !prio) rr_m[k] = !rr_m[k];
            if (mism) err_m[k] = 1'b1;
            if (!rst_n) clear_model(k);
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic b, input logic [127:0] x,
                         input logic [127:0] y, input logic [2:0] j);
        rst_n = r;
        v0    = a;
        v1    = b;
        s0    = x;
        s1    = y;
        inj   = j;
    endtask

    task automatic close_cycle();
        model_cycle();
        @(posedge clk);
        #1;
        c++;
    endtask

    typedef struct {
        logic        rst;
        logic        a;
        logic        b;
        logic [1:0]  rdy_rr;
        logic [1:0]  rdy_pr;
        logic [1:0]  rsp_rr;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // Contention: state 0 from requester 0, key word 1 from requester 1.
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 2'b00, 32'h0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 2'b01, 2'b10, 2'b10, 32'h63636363};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 2'b01, 32'h6363637c};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 2'b01, 2'b10, 2'b10, 32'h63636363};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 2'b01, 32'h6363637c};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'b01, 2'b10, 2'b10, 32'h63636363};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 32'h6363637c};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 32'h6363637c};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 32'h63636363};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0};

        for (int k = 0; k < 3; k++) clear_model(k);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rst, tbl[i].a, tbl[i].b, 128'h0, 128'h1, 3'b000);
            #4;
            chk($sformatf("tbl%0d rr ready", i), {rdy0[0], rdy1[0]}, tbl[i].rdy_rr);
            chk($sformatf("tbl%0d prio ready", i), {rdy0[2], rdy1[2]}, tbl[i].rdy_pr);
            chk($sformatf("tbl%0d rr rsp", i), {rsp0[0], rsp1[0]}, tbl[i].rsp_rr);
            if (tbl[i].rsp_rr != 2'b00) begin
                chk($sformatf("tbl%0d rr rsp low word", i), rsp_st[0][31:0], tbl[i].lo);
            end
            if (!tbl[i].rst) begin
                chk($sformatf("tbl%0d reset busy/err/sb", i), {busy, err}, 6'b0);
            end
            close_cycle();
        end

        // Reset while two words are in flight on the latency-1 instance.
        drive(1'b1, 1'b1, 1'b0, 128'h00112233445566778899aabbccddeeff, '0, 3'b000);
        #4;
        close_cycle();
        drive(1'b1, 1'b1, 1'b0, 128'hdeadbeef0123456789abcdef00000001, '0, 3'b000);
        #4;
        close_cycle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
        #4;
        chk("midrst rsp in reset", {rsp0[1], rsp1[1]}, 2'b00);
        close_cycle();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b000);
        #4;
        chk("midrst rsp after", {rsp0[1], rsp1[1]}, 2'b00);
        chk("midrst busy after", busy[1], 1'b0);
        close_cycle();

        // Spurious bank valid with an empty pipeline.
        drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b111);
        #4;
        chk("inject rsp suppressed", {rsp0, rsp1}, 6'b0);
        close_cycle();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b000);
        #4;
        chk("error set", err, 3'b111);
        close_cycle();
        drive(1'b1, 1'b1, 1'b0, 128'h0, '0, 3'b000);
        #4;
        close_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b000);
            #4;
            close_cycle();
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b000);
        #4;
        chk("error sticky", err, 3'b111);
        close_cycle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
        #4;
        close_cycle();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b000);
        #4;
        chk("error cleared", err, 3'b000);
        close_cycle();

        for (int i = 0; i < 600; i++) begin
            logic         r;
            logic [2:0]   j;
            logic [127:0] x;
            logic [127:0] y;
            r = ($urandom_range(0, 39) != 0);
            j = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            x = {$urandom, $urandom, $urandom, $urandom};
            y = {96'h0, $urandom};
            drive(r, 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 6), x, y, j);
            #4;
            close_cycle();
        end

        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
        #4;
        close_cycle();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b000);
        #4;
        close_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
